// File: rtl/line_fifo_pkg.sv
// Shared types and helpers for the conv2d line-FIFO read sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package line_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LINES,
    ST_READ,
    ST_ROW_END,
    ST_DONE
  } state_t;

  // Width of the kernel-line index (at least one bit).
  function automatic int kline_w(input int kernel_lines);
    return (kernel_lines > 1) ? $clog2(kernel_lines) : 1;
  endfunction

  // Width of the word-within-line index (at least one bit).
  function automatic int word_w(input int words_per_line);
    return (words_per_line > 1) ? $clog2(words_per_line) : 1;
  endfunction

  // Line counter needs headroom above NUM_LINES to saturate and flag overflow.
  function automatic int lcnt_w(input int num_lines);
    return $clog2(num_lines + 1) + 1;
  endfunction

  // Advance a word address around the ring; step never exceeds the ring size.
  function automatic logic [31:0] ring_advance(input logic [31:0] cur,
                                               input logic [31:0] step,
                                               input logic [31:0] total);
    logic [31:0] sum;
    sum = cur + step;
    return (sum >= total) ? (sum - total) : sum;
  endfunction

endpackage

// File: rtl/line_fifo_rd_ctrl_tag_pipe.sv
// Valid/tag delay line matching a block-RAM read latency.
// Latency: DEPTH cycles from i_vld/i_tag to o_vld/o_tag.
// Backpressure: none; always shifts, upstream must absorb DEPTH in-flight words.
module rd_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_vld,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_vld,
  output logic [TAG_W-1:0] o_tag
);

  logic [DEPTH-1:0] vld_sr;
  logic [TAG_W-1:0] tag_sr [DEPTH];

  // Shift valid and tag one stage per cycle; reset flushes in-flight words.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_sr <= '0;
      for (int i = 0; i < DEPTH; i++) tag_sr[i] <= '0;
    end else begin
      vld_sr[0] <= i_vld;
      tag_sr[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

  assign o_vld = vld_sr[DEPTH-1];
  assign o_tag = tag_sr[DEPTH-1];

endmodule

// File: rtl/line_fifo_rd_ctrl.sv
// Read sequencer for the conv2d line ring buffer: waits for a kernel window, reads it row by row.
// Latency: o_rd_en same cycle as READ state; tags/valid follow RD_LATENCY cycles later.
// Backpressure: i_stall holds all counters and suppresses reads; RD_LATENCY words still drain.
module line_fifo_rd_ctrl
  import line_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int WORDS_PER_LINE = 57,
  parameter int NUM_LINES      = 15,
  parameter int KERNEL_LINES   = 11,
  parameter int STRIDE         = 4,
  parameter int OUT_ROWS       = 55,
  parameter int RD_LATENCY     = 2
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_start,
  input  logic                                 i_line_written,
  input  logic                                 i_stall,
  output logic                                 o_wr_addr_reset,
  output logic                                 o_rd_en,
  output logic [ADDR_WIDTH-1:0]                o_rd_addr,
  output logic                                 o_data_valid,
  output logic [kline_w(KERNEL_LINES)-1:0]     o_kline,
  output logic [word_w(WORDS_PER_LINE)-1:0]    o_word,
  output logic                                 o_row_last,
  output logic                                 o_line_release,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_overflow
);

  localparam int KLINE_W = kline_w(KERNEL_LINES);
  localparam int WORD_W  = word_w(WORDS_PER_LINE);
  localparam int LCNT_W  = lcnt_w(NUM_LINES);
  localparam int ROW_W   = $clog2(OUT_ROWS + 1);
  localparam int TAG_W   = 1 + KLINE_W + WORD_W;
  localparam logic [31:0] RING_WORDS   = 32'(NUM_LINES * WORDS_PER_LINE);
  localparam logic [31:0] STRIDE_WORDS = 32'(STRIDE * WORDS_PER_LINE);

  state_t                state;
  logic [LCNT_W-1:0]     lines_avail;
  logic [ADDR_WIDTH-1:0] base_start;   // start address of the window's first line
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [KLINE_W-1:0]    kline;
  logic [WORD_W-1:0]     word;
  logic [ROW_W-1:0]      row_cnt;
  logic                  overflow;
  logic                  wr_addr_reset;
  logic                  line_release;
  logic                  done;

  logic                  rd_issue;
  logic                  last_word;
  logic                  last_kline;
  logic [LCNT_W:0]       lcnt_sum;
  logic                  lcnt_sat;
  logic [LCNT_W-1:0]     lcnt_next;
  logic [TAG_W-1:0]      tag_out;

  assign rd_issue   = (state == ST_READ) && !i_stall;
  assign last_word  = (word == WORD_W'(WORDS_PER_LINE - 1));
  assign last_kline = (kline == KLINE_W'(KERNEL_LINES - 1));

  // Next line count: start clears, writes add one, a row end frees STRIDE lines.
  always_comb begin
    lcnt_sum = i_start ? '0 : {1'b0, lines_avail};
    if (i_line_written && (i_start || state != ST_IDLE))
      lcnt_sum = lcnt_sum + (LCNT_W+1)'(1);
    if (!i_start && state == ST_ROW_END)
      lcnt_sum = lcnt_sum - (LCNT_W+1)'(STRIDE);
    lcnt_sat  = (lcnt_sum > (LCNT_W+1)'(NUM_LINES));
    lcnt_next = lcnt_sat ? LCNT_W'(NUM_LINES + 1) : lcnt_sum[LCNT_W-1:0];
  end

  // Sequencer FSM with its counters and registered pulse outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      lines_avail   <= '0;
      base_start    <= '0;
      rd_addr       <= '0;
      kline         <= '0;
      word          <= '0;
      row_cnt       <= '0;
      overflow      <= 1'b0;
      wr_addr_reset <= 1'b0;
      line_release  <= 1'b0;
      done          <= 1'b0;
    end else begin
      wr_addr_reset <= i_start;
      line_release  <= 1'b0;
      done          <= 1'b0;
      lines_avail   <= lcnt_next;
      overflow      <= i_start ? 1'b0 : (overflow | lcnt_sat);
      if (i_start) begin
        state      <= ST_WAIT_LINES;
        base_start <= '0;
        rd_addr    <= '0;
        kline      <= '0;
        word       <= '0;
        row_cnt    <= '0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_WAIT_LINES: begin
            if (lines_avail >= LCNT_W'(KERNEL_LINES)) begin
              state   <= ST_READ;
              rd_addr <= base_start;
              kline   <= '0;
              word    <= '0;
            end
          end
          ST_READ: begin
            if (rd_issue) begin
              rd_addr <= ADDR_WIDTH'(ring_advance(32'(rd_addr), 32'd1, RING_WORDS));
              if (last_word) begin
                word <= '0;
                if (last_kline) begin
                  kline        <= '0;
                  state        <= ST_ROW_END;
                  line_release <= 1'b1;
                end else begin
                  kline <= kline + KLINE_W'(1);
                end
              end else begin
                word <= word + WORD_W'(1);
              end
            end
          end
          ST_ROW_END: begin
            base_start <= ADDR_WIDTH'(ring_advance(32'(base_start), STRIDE_WORDS, RING_WORDS));
            row_cnt    <= row_cnt + ROW_W'(1);
            if (row_cnt == ROW_W'(OUT_ROWS - 1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_WAIT_LINES;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LATENCY),
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_vld   (rd_issue),
    .i_tag   ({last_word && last_kline, kline, word}),
    .o_vld   (o_data_valid),
    .o_tag   (tag_out)
  );

  assign o_row_last      = tag_out[TAG_W-1];
  assign o_kline         = tag_out[WORD_W +: KLINE_W];
  assign o_word          = tag_out[WORD_W-1:0];
  assign o_rd_en         = rd_issue;
  assign o_rd_addr       = rd_addr;
  assign o_busy          = (state != ST_IDLE);
  assign o_wr_addr_reset = wr_addr_reset;
  assign o_line_release  = line_release;
  assign o_done          = done;
  assign o_overflow      = overflow;

endmodule

// File: tb/tb_line_fifo_rd_ctrl.sv
// Bench for line_fifo_rd_ctrl: control vectors from a table, read stream via scoreboard.
// Latency: checks o_data_valid exactly RD_LATENCY cycles after each o_rd_en.
// Backpressure: exercises i_stall mid-row and the trailing in-flight words.
module tb_line_fifo_rd_ctrl;

  localparam int AW  = 11;
  localparam int WPL = 4;
  localparam int NL  = 6;
  localparam int KL  = 3;
  localparam int ST  = 2;
  localparam int OR  = 3;
  localparam int RL  = 2;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_start = 1'b0;
  logic          i_line_written = 1'b0;
  logic          i_stall = 1'b0;
  logic          o_wr_addr_reset, o_rd_en, o_data_valid, o_row_last;
  logic          o_line_release, o_busy, o_done, o_overflow;
  logic [AW-1:0] o_rd_addr;
  logic [1:0]    o_kline;
  logic [1:0]    o_word;

  line_fifo_rd_ctrl #(
    .ADDR_WIDTH(AW), .WORDS_PER_LINE(WPL), .NUM_LINES(NL), .KERNEL_LINES(KL),
    .STRIDE(ST), .OUT_ROWS(OR), .RD_LATENCY(RL)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_line_written(i_line_written), .i_stall(i_stall),
    .o_wr_addr_reset(o_wr_addr_reset), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .o_data_valid(o_data_valid), .o_kline(o_kline), .o_word(o_word),
    .o_row_last(o_row_last), .o_line_release(o_line_release), .o_busy(o_busy),
    .o_done(o_done), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct { int addr; int kl; int wd; bit last; } rd_t;
  typedef struct { rd_t r; int due; } vexp_t;
  rd_t   exp_q[$];
  vexp_t v_q[$];

  typedef struct {
    int reps;
    bit st, lw, stall;
    bit busy, rden, rel, done, ovf, wrr;
    bit chk_a;
    int addr;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected read stream of one whole image, from the closed-form address.
  task automatic push_image();
    rd_t e;
    exp_q.delete();
    for (int r = 0; r < OR; r++)
      for (int kl = 0; kl < KL; kl++)
        for (int w = 0; w < WPL; w++) begin
          e.addr = ((((r * ST) % NL) + kl) % NL) * WPL + w;
          e.kl   = kl;
          e.wd   = w;
          e.last = (kl == KL - 1) && (w == WPL - 1);
          exp_q.push_back(e);
        end
  endtask

  // Scoreboard: match each issued read, then its tagged data RL cycles later.
  always @(negedge i_clk) begin : monitor
    rd_t   e;
    vexp_t v;
    if (!i_reset) begin
      if (v_q.size() > 0 && v_q[0].due < cyc) begin
        v = v_q.pop_front();
        n_checks++; n_fail++;
        $display("FAIL dv_missing: no o_data_valid at cycle %0d for addr %0d", v.due, v.r.addr);
      end
      if (o_rd_en) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_extra: o_rd_en with addr %0d, none expected", o_rd_addr);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rd_addr@%0d", cyc), int'(o_rd_addr), e.addr);
          v.r = e;
          v.due = cyc + RL;
          v_q.push_back(v);
        end
      end
      if (o_data_valid) begin
        if (v_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dv_extra: o_data_valid at cycle %0d, none expected", cyc);
        end else begin
          v = v_q.pop_front();
          chk($sformatf("dv_cycle@%0d", cyc), cyc, v.due);
          chk($sformatf("dv_kline@%0d", cyc), int'(o_kline), v.r.kl);
          chk($sformatf("dv_word@%0d", cyc), int'(o_word), v.r.wd);
          chk($sformatf("dv_last@%0d", cyc), int'(o_row_last), int'(v.r.last));
        end
      end
    end
  end

  // One cycle: drive at posedge+1, sample just after the following negedge.
  task automatic step(input bit s, input bit lw, input bit stl);
    @(posedge i_clk);
    #1;
    i_start = s;
    i_line_written = lw;
    i_stall = stl;
    @(negedge i_clk);
    #1;
    if (s) push_image();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_rd_en"}, o_rd_en, 0);
    chk({tag, "_rd_addr"}, int'(o_rd_addr), 0);
    chk({tag, "_dv"}, o_data_valid, 0);
    chk({tag, "_kline"}, int'(o_kline), 0);
    chk({tag, "_word"}, int'(o_word), 0);
    chk({tag, "_row_last"}, o_row_last, 0);
    chk({tag, "_release"}, o_line_release, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_ovf"}, o_overflow, 0);
    chk({tag, "_wr_rst"}, o_wr_addr_reset, 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int seen;
    int waited;
    // reps  st lw sl | busy rden rel done ovf wrr | chk addr
    tbl.push_back('{1,  1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0});   // start
    tbl.push_back('{1,  0, 1, 0,  1, 0, 0, 0, 0, 1,  0, 0});   // wr reset pulse
    tbl.push_back('{1,  0, 1, 0,  1, 0, 0, 0, 0, 0,  0, 0});
    tbl.push_back('{2,  0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0});   // 2 lines: waits
    tbl.push_back('{1,  0, 1, 0,  1, 0, 0, 0, 0, 0,  0, 0});   // third line
    tbl.push_back('{1,  0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0});   // sees 3 lines
    tbl.push_back('{6,  0, 0, 0,  1, 1, 0, 0, 0, 0,  1, 0});   // addr 0..5
    tbl.push_back('{5,  0, 0, 1,  1, 0, 0, 0, 0, 0,  1, 6});   // stall holds 6
    tbl.push_back('{6,  0, 0, 0,  1, 1, 0, 0, 0, 0,  1, 6});   // addr 6..11
    tbl.push_back('{1,  0, 0, 0,  1, 0, 1, 0, 0, 0,  0, 0});   // row end
    tbl.push_back('{2,  0, 1, 0,  1, 0, 0, 0, 0, 0,  0, 0});
    tbl.push_back('{1,  0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0});
    tbl.push_back('{1,  0, 1, 0,  1, 1, 0, 0, 0, 0,  1, 8});   // row 1, lines -> 4
    tbl.push_back('{11, 0, 0, 0,  1, 1, 0, 0, 0, 0,  1, 9});   // addr 9..19
    tbl.push_back('{1,  0, 1, 0,  1, 0, 1, 0, 0, 0,  0, 0});   // write on row end: 4-2+1
    tbl.push_back('{1,  0, 0, 0,  1, 0, 0, 0, 0, 0,  0, 0});
    tbl.push_back('{4,  0, 1, 0,  1, 1, 0, 0, 0, 0,  1, 16});  // 4 extra lines
    tbl.push_back('{4,  0, 0, 0,  1, 1, 0, 0, 1, 0,  1, 20});  // overflow sticky
    tbl.push_back('{4,  0, 0, 0,  1, 1, 0, 0, 1, 0,  1, 0});   // ring wrap 0..3
    tbl.push_back('{1,  0, 0, 0,  1, 0, 1, 0, 1, 0,  0, 0});   // last row end
    tbl.push_back('{1,  0, 0, 0,  1, 0, 0, 1, 1, 0,  0, 0});   // done
    tbl.push_back('{2,  0, 0, 0,  0, 0, 0, 0, 1, 0,  0, 0});   // idle, still sticky
    tbl.push_back('{1,  1, 0, 0,  0, 0, 0, 0, 1, 0,  0, 0});   // start clears ovf
    tbl.push_back('{1,  0, 0, 0,  1, 0, 0, 0, 0, 1,  0, 0});

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].reps; j++) begin
        step(tbl[i].st, tbl[i].lw, tbl[i].stall);
        chk($sformatf("v%0d.%0d_busy", i, j), o_busy, tbl[i].busy);
        chk($sformatf("v%0d.%0d_rd_en", i, j), o_rd_en, tbl[i].rden);
        chk($sformatf("v%0d.%0d_release", i, j), o_line_release, tbl[i].rel);
        chk($sformatf("v%0d.%0d_done", i, j), o_done, tbl[i].done);
        chk($sformatf("v%0d.%0d_ovf", i, j), o_overflow, tbl[i].ovf);
        chk($sformatf("v%0d.%0d_wr_rst", i, j), o_wr_addr_reset, tbl[i].wrr);
        if (tbl[i].chk_a)
          chk($sformatf("v%0d.%0d_addr", i, j), int'(o_rd_addr),
              tbl[i].addr + (tbl[i].rden ? j : 0));
      end
    end

    // Restart mid-row: in-flight data drains, sequencer rewinds to base 0.
    repeat (3) step(0, 1, 0);
    seen = 0; waited = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      step(0, 0, 0);
      if (o_rd_en) seen = 1; else waited++;
    end
    chk("t6_read_seen", seen, 1);
    chk("t6_wait_cycles", waited, 1);
    repeat (4) step(0, 0, 0);
    step(1, 0, 0);
    chk("t6_start_cycle_rd_en", o_rd_en, 1);
    step(0, 0, 0);
    chk("t6_wr_rst_pulse", o_wr_addr_reset, 1);
    chk("t6_busy", o_busy, 1);
    chk("t6_rd_en_waiting", o_rd_en, 0);
    step(0, 0, 0);
    chk("t6_wr_rst_clear", o_wr_addr_reset, 0);
    repeat (3) step(0, 1, 0);
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      step(0, 0, 0);
      if (o_rd_en) seen = 1;
    end
    chk("t6_restart_seen", seen, 1);
    chk("t6_restart_addr", int'(o_rd_addr), 0);
    repeat (3) step(0, 0, 0);

    // Asynchronous reset in the middle of a row.
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
    exp_q.delete();
    v_q.delete();
    #1;
    chk_all_zero("midrst");
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    repeat (4) begin
      step(0, 1, 0);
      chk("post_rst_busy", o_busy, 0);
      chk("post_rst_rd_en", o_rd_en, 0);
    end
    chk("sb_pending_valid", v_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_fifo_rd_ctrl.md
Name: line_fifo_rd_ctrl

Overview:
Read-side sequencer for the conv2d image line FIFO. Tracks how many complete image lines the write side has deposited into the circular line buffer. Once a full kernel window of lines is present, issues one output row's worth of read addresses (KERNEL_LINES lines x WORDS_PER_LINE words) to the line buffer and tags the returning data for the MLP array. After each row it advances the ring base by STRIDE lines, releases those lines to the writer, and repeats until OUT_ROWS rows are done.

Parameters:
ADDR_WIDTH, 11, line-buffer word address width
WORDS_PER_LINE, 57, 144-bit words per image line
NUM_LINES, 15, lines held in the ring buffer; must be >= KERNEL_LINES+STRIDE
KERNEL_LINES, 11, lines per convolution window
STRIDE, 4, lines advanced per output row
OUT_ROWS, 55, output rows per image
RD_LATENCY, 2, line-buffer read latency in cycles (output register enabled)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_start  in  1  pulse: new image; restarts sequencer from any state
i_line_written  in  1  pulse: one full line written to the buffer
i_stall  in  1  downstream backpressure; suppresses new reads
o_wr_addr_reset  out  1  pulse to the buffer write-address reset, one cycle after i_start
o_rd_en  out  1  read issued this cycle
o_rd_addr  out  ADDR_WIDTH  buffer read address
o_data_valid  out  1  buffer output valid (o_rd_en delayed RD_LATENCY)
o_kline  out  $clog2(KERNEL_LINES)  kernel line index of valid data
o_word  out  $clog2(WORDS_PER_LINE)  word index of valid data
o_row_last  out  1  with o_data_valid: final word of the row
o_line_release  out  1  pulse: STRIDE lines freed for overwrite
o_busy  out  1  image in progress
o_done  out  1  pulse: last row fully issued
o_overflow  out  1  sticky: line count exceeded NUM_LINES

Behaviour:
- Reset: all outputs 0; FSM IDLE; counters 0. Reset mid-row abandons the row; the in-flight valid pipeline is cleared.
- FSM states: IDLE, WAIT_LINES, READ, ROW_END, DONE.
  - IDLE -> WAIT_LINES on i_start.
  - WAIT_LINES -> READ when lines_avail >= KERNEL_LINES.
  - READ -> ROW_END after issuing word WORDS_PER_LINE-1 of kline KERNEL_LINES-1.
  - ROW_END: pulse o_line_release; lines_avail -= STRIDE; base_line = (base_line+STRIDE) mod NUM_LINES; row_cnt++. If row_cnt == OUT_ROWS go to DONE, else go to WAIT_LINES.
  - DONE: pulse o_done for one cycle, then IDLE.
- i_start in any state: clears lines_avail, base_line, row_cnt, and overflow; pulses o_wr_addr_reset the next cycle; enters WAIT_LINES. Reads already in flight still complete on o_data_valid.
- lines_avail: +1 on i_line_written in every non-IDLE state, including the cycle of i_start after the clear. A simultaneous ROW_END decrement nets +1-STRIDE. Width is $clog2(NUM_LINES+1)+1. The counter saturates at NUM_LINES+1 and sets o_overflow.
- Read order is line-major: kline outer, word inner.
  - Address = ((base_line+kline) mod NUM_LINES)*WORDS_PER_LINE + word.
  - Computed incrementally: line start address advances by WORDS_PER_LINE and wraps to 0 past line NUM_LINES-1. No multiplier.
- o_rd_en = (state==READ) && !i_stall. While stalled, all counters hold. The buffer reads continuously, so the consumer absorbs up to RD_LATENCY in-flight words after asserting i_stall.
- o_data_valid, o_kline, o_word, and o_row_last are the issue-time values delayed through a RD_LATENCY-deep shift register.
- Throughput is 1 word/cycle in READ. ROW_END costs 1 cycle per row.
- o_busy = state != IDLE.

Decomposition:
- Shared package line_fifo_pkg:
  - FSM state enum.
  - Derived widths: KLINE_W, WORD_W, LCNT_W.
  - Helper function for the ring-wrapped line start address.
- One sub-module: rd_tag_pipe, the RD_LATENCY-deep valid/tag delay line. It is reusable for other BRAM read paths.

Test Plan:
Test configuration: WORDS_PER_LINE=4, NUM_LINES=6, KERNEL_LINES=3, STRIDE=2, OUT_ROWS=3, RD_LATENCY=2.
1. i_start, then 3 i_line_written pulses -> READ begins the cycle after lines_avail=3. o_rd_addr runs 0..11 contiguously. o_data_valid trails o_rd_en by exactly 2 cycles. o_row_last appears on the 12th valid word.
2. Continue with 2 more lines -> row 1 addresses 8..19, preceded by one o_line_release pulse. Add 2 more lines -> row 2 addresses 16..23 then 0..3 (ring wrap), followed by an o_done pulse and IDLE.
3. Only 2 lines written after i_start -> stays in WAIT_LINES with o_rd_en=0. The third line starts reads on the following cycle.
4. i_stall high for 5 cycles mid-row at address 6 -> no o_rd_en and address holds at 6. Exactly 2 trailing o_data_valid occur. Resumes at 6 with no duplicate or skipped address.
5. i_line_written coincident with the ROW_END cycle while lines_avail=4 -> lines_avail becomes 3. Then 4 extra lines beyond capacity -> o_overflow set and sticky until i_start.
6. Assert i_reset during READ -> all outputs 0 immediately. i_start mid-row -> o_wr_addr_reset pulses one cycle later and the sequencer returns to base 0 in WAIT_LINES.
